// File: rtl/spi_slave_all_modes_pkg.sv
// Shared types and constants for the SPI slave.
// State encoding, mode codes and byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_all_modes_if.sv
// User-side TX/RX handshake and SPI pins of the slave.
// slave = the SPI slave block, master = whatever drives it.
interface spi_slave_all_modes_if;
    import spi_pkg::*;

    logic                  i_CPOL;
    logic                  i_CPHA;
    logic [SPI_BYTE_W-1:0] i_TX_Byte;
    logic                  i_TX_DV;
    logic                  o_TX_Ready;
    logic                  o_TX_Underrun;
    logic                  o_RX_DV;
    logic [SPI_BYTE_W-1:0] o_RX_Byte;
    logic                  i_SPI_Clk;
    logic                  i_SPI_MOSI;
    logic                  i_SPI_CS_n;
    logic                  o_SPI_MISO;
    logic                  o_SPI_MISO_OE;

    modport slave (
        input  i_CPOL, i_CPHA, i_TX_Byte, i_TX_DV,
        input  i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
        output o_TX_Ready, o_TX_Underrun,
        output o_RX_DV, o_RX_Byte,
        output o_SPI_MISO, o_SPI_MISO_OE
    );

    modport master (
        output i_CPOL, i_CPHA, i_TX_Byte, i_TX_DV,
        output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
        input  o_TX_Ready, o_TX_Underrun,
        input  o_RX_DV, o_RX_Byte,
        input  o_SPI_MISO, o_SPI_MISO_OE
    );

endinterface

// File: rtl/spi_slave_all_modes_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with
// single-cycle rise/fall pulses on the synced value.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_D,
    output logic o_Q,
    output logic o_Rise,
    output logic o_Fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_D};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_Q    = sync_q[STAGES-1];
    assign o_Rise = o_Q & ~prev_q;
    assign o_Fall = ~o_Q & prev_q;

endmodule

// File: rtl/spi_slave_all_modes.sv
// SPI slave for all CPOL/CPHA modes, oversampled in i_Clk,
// with a one-deep TX holding register and multi-byte frames.
module spi_slave_all_modes
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    spi_slave_all_modes_if.slave        bus
);

    localparam logic [SPI_CNT_W-1:0] LAST_BIT =
        SPI_CNT_W'(SPI_BYTE_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sclk (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     (bus.i_SPI_Clk),
        .o_Q     (sclk_s),
        .o_Rise  (sclk_rise),
        .o_Fall  (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_D     (bus.i_SPI_CS_n),
        .o_Q     (cs_s),
        .o_Rise  (cs_rise),
        .o_Fall  (cs_fall)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e                 state_q;
    logic [1:0]                 mode_q;
    logic [SPI_CNT_W-1:0]       bit_cnt_q;
    logic [SPI_BYTE_W-2:0]      rx_sh_q;
    logic [SPI_BYTE_W-1:0]      tx_sh_q;
    logic [SPI_BYTE_W-1:0]      hold_q;
    logic                       hold_full_q;
    logic                       rx_dv_q;
    logic [SPI_BYTE_W-1:0]      rx_byte_q;
    logic                       urun_q;
    logic                       miso_q;
    logic                       oe_q;

    logic sclk_edge, lead_e, trail_e;
    logic sample_e, shift_e;
    logic frame_on, load;
    logic [SPI_BYTE_W-1:0] tx_load_d;

    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead_e    = sclk_edge & (sclk_s != mode_q[1]);
    assign trail_e   = sclk_edge & (sclk_s == mode_q[1]);

    always_comb begin
        sample_e = 1'b0;
        shift_e  = 1'b0;
        unique case (mode_q)
            MODE0, MODE2: begin
                sample_e = lead_e;
                shift_e  = trail_e;
            end
            MODE1, MODE3: begin
                sample_e = trail_e;
                shift_e  = lead_e;
            end
        endcase
    end

    assign frame_on = (state_q == ACTIVE) && !cs_s;

    // Counter at zero on a shift edge is end-of-byte for CPHA=0
    // and start-of-byte for CPHA=1; both are load points.
    assign load =
        (state_q == IDLE && cs_fall && !bus.i_CPHA) ||
        (frame_on && shift_e && bit_cnt_q == '0);

    assign tx_load_d = hold_full_q ? hold_q :
                       bus.i_TX_DV ? bus.i_TX_Byte : '0;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            mode_q      <= MODE0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= '0;
            urun_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            urun_q  <= 1'b0;

            if (load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (!load && !hold_full_q && bus.i_TX_DV) begin
                hold_q      <= bus.i_TX_Byte;
                hold_full_q <= 1'b1;
            end

            if (load) begin
                tx_sh_q <= tx_load_d;
                miso_q  <= tx_load_d[SPI_BYTE_W-1];
                urun_q  <= !hold_full_q && !bus.i_TX_DV;
            end

            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ACTIVE;
                        mode_q    <= {bus.i_CPOL, bus.i_CPHA};
                        bit_cnt_q <= '0;
                        oe_q      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                        miso_q  <= 1'b0;
                    end else if (frame_on) begin
                        if (shift_e && bit_cnt_q != '0) begin
                            tx_sh_q <= {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
                            miso_q  <= tx_sh_q[SPI_BYTE_W-2];
                        end
                        if (sample_e) begin
                            rx_sh_q   <= {rx_sh_q[SPI_BYTE_W-3:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                rx_byte_q <= {rx_sh_q, mosi_s};
                                rx_dv_q   <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.o_TX_Ready    = ~hold_full_q;
    assign bus.o_TX_Underrun = urun_q;
    assign bus.o_RX_DV       = rx_dv_q;
    assign bus.o_RX_Byte     = rx_byte_q;
    assign bus.o_SPI_MISO    = miso_q;
    assign bus.o_SPI_MISO_OE = oe_q;

endmodule

// File: tb/tb_spi_slave_all_modes.sv
// Bench for spi_slave_all_modes: a behavioural SPI master
// drives frames and results are compared with a simple model.
module tb_spi_slave_all_modes;

    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_slave_all_modes_if sif ();

    spi_slave_all_modes #(
        .SYNC_STAGES (2)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (sif)
    );

    int vectors     = 0;
    int miscompares = 0;
    int urun_cnt    = 0;

    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.o_RX_DV) rx_q.push_back(sif.o_RX_Byte);
            if (sif.o_TX_Underrun) urun_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_obs();
        rx_q.delete();
        urun_cnt = 0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        sif.i_CPOL    = m[1];
        sif.i_CPHA    = m[0];
        sif.i_SPI_Clk = m[1];
        repeat (6) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] v);
        int n;
        n = 0;
        while (!sif.o_TX_Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!sif.o_TX_Ready) begin
            miscompares++;
            $display("FAIL preload_wait: ready=%b want 1", sif.o_TX_Ready);
        end
        sif.i_TX_Byte = v;
        sif.i_TX_DV   = 1'b1;
        @(negedge clk);
        sif.i_TX_DV   = 1'b0;
        vectors++;
        if (sif.o_TX_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL preload_ready: got %b want 0", sif.o_TX_Ready);
        end
    endtask

    // Master: sets data on its shift edge, samples on its sample edge.
    task automatic master_xfer(input int nbits, input bit byp_en,
                               input logic [7:0] byp);
        logic [7:0] cur;
        logic cpol, cpha;
        cpol = sif.i_CPOL;
        cpha = sif.i_CPHA;
        cur  = 8'h00;
        m_rx.delete();
        @(negedge clk);
        sif.i_SPI_CS_n = 1'b0;
        if (!cpha) sif.i_SPI_MOSI = m_tx[0][7];
        repeat (2) @(negedge clk);
        vectors++;
        if (sif.o_SPI_MISO_OE !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_early: got %b want 0", sif.o_SPI_MISO_OE);
        end
        if (byp_en) begin
            sif.i_TX_Byte = byp;
            sif.i_TX_DV   = 1'b1;
        end
        @(negedge clk);
        sif.i_TX_DV = 1'b0;
        vectors++;
        if (sif.o_SPI_MISO_OE !== 1'b1) begin
            miscompares++;
            $display("FAIL oe_rise: got %b want 1", sif.o_SPI_MISO_OE);
        end
        if (byp_en) begin
            vectors++;
            if (sif.o_TX_Ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bypass_ready: got %b want 1", sif.o_TX_Ready);
            end
        end
        repeat (H - 3) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (cpha) sif.i_SPI_MOSI = m_tx[b / 8][7 - (b % 8)];
            sif.i_SPI_Clk = ~cpol;
            if (!cpha) cur = {cur[6:0], sif.o_SPI_MISO};
            repeat (H) @(negedge clk);
            sif.i_SPI_Clk = cpol;
            if (cpha) cur = {cur[6:0], sif.o_SPI_MISO};
            else if (b + 1 < nbits)
                sif.i_SPI_MOSI = m_tx[(b + 1) / 8][7 - ((b + 1) % 8)];
            if (b % 8 == 7) m_rx.push_back(cur);
            repeat (H) @(negedge clk);
        end
        sif.i_SPI_CS_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (sif.o_SPI_MISO_OE !== 1'b1) begin
            miscompares++;
            $display("FAIL oe_hold: got %b want 1", sif.o_SPI_MISO_OE);
        end
        @(negedge clk);
        vectors++;
        if (sif.o_SPI_MISO_OE !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_fall: got %b want 0", sif.o_SPI_MISO_OE);
        end
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic check_outputs_reset(input string tag);
        vectors++;
        if (sif.o_TX_Ready !== 1'b1 || sif.o_TX_Underrun !== 1'b0 ||
            sif.o_RX_DV !== 1'b0 || sif.o_RX_Byte !== 8'h00 ||
            sif.o_SPI_MISO !== 1'b0 || sif.o_SPI_MISO_OE !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: rdy=%b ur=%b dv=%b rx=%h miso=%b oe=%b want 1 0 0 00 0 0",
                     tag, sif.o_TX_Ready, sif.o_TX_Underrun, sif.o_RX_DV,
                     sif.o_RX_Byte, sif.o_SPI_MISO, sif.o_SPI_MISO_OE);
        end
    endtask

    task automatic check_rx1(input string tag, input logic [7:0] want);
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d bytes first=%h want 1 byte %h",
                     tag, rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, want);
        end
    endtask

    task automatic check_miso1(input string tag, input logic [7:0] want);
        vectors++;
        if (m_rx.size() < 1 || m_rx[0] !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h",
                     tag, m_rx.size() ? m_rx[0] : 8'hxx, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sif.i_CPOL = 0; sif.i_CPHA = 0;
        sif.i_TX_Byte = 0; sif.i_TX_DV = 0;
        sif.i_SPI_Clk = 0; sif.i_SPI_MOSI = 0; sif.i_SPI_CS_n = 1;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset_values");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mode0();
        set_mode(2'b00);
        clear_obs();
        preload(8'h3C);
        m_tx = '{8'hA5};
        master_xfer(8, 0, 8'h00);
        check_rx1("mode0_rx", 8'hA5);
        check_miso1("mode0_miso", 8'h3C);
        vectors++;
        if (sif.o_TX_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mode0_ready: got %b want 1", sif.o_TX_Ready);
        end
    endtask

    task automatic test_all_modes();
        for (int m = 0; m < 4; m++) begin
            set_mode(2'(m));
            clear_obs();
            preload(8'h81);
            m_tx = '{8'h7E};
            master_xfer(8, 0, 8'h00);
            check_rx1($sformatf("mode%0d_rx", m), 8'h7E);
            check_miso1($sformatf("mode%0d_miso", m), 8'h81);
        end
    endtask

    task automatic test_underrun();
        set_mode(2'b01);
        clear_obs();
        m_tx = '{8'hFF};
        master_xfer(8, 0, 8'h00);
        check_miso1("underrun_miso", 8'h00);
        check_rx1("underrun_rx", 8'hFF);
        vectors++;
        if (urun_cnt != 1) begin
            miscompares++;
            $display("FAIL underrun_cnt: got %0d want 1", urun_cnt);
        end
    endtask

    task automatic test_abort();
        set_mode(2'b00);
        clear_obs();
        m_tx = '{8'hC3};
        master_xfer(5, 0, 8'h00);
        vectors++;
        if (rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_rxdv: got %0d pulses want 0", rx_q.size());
        end
        clear_obs();
        m_tx = '{8'h5A};
        master_xfer(8, 0, 8'h00);
        check_rx1("abort_next_rx", 8'h5A);
    endtask

    task automatic test_back_to_back();
        set_mode(2'b01);
        clear_obs();
        preload(8'hAA);
        m_tx = '{8'h11, 8'h22};
        fork
            master_xfer(16, 0, 8'h00);
            begin
                int n;
                n = 0;
                while (!sif.o_TX_Ready && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                vectors++;
                if (!sif.o_TX_Ready) begin
                    miscompares++;
                    $display("FAIL burst_ready_wait: got 0 want 1");
                end else begin
                    sif.i_TX_Byte = 8'h55;
                    sif.i_TX_DV   = 1'b1;
                    @(negedge clk);
                    sif.i_TX_DV   = 1'b0;
                end
            end
        join
        vectors++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin
            miscompares++;
            $display("FAIL burst_rx: got %0d bytes want 11,22", rx_q.size());
        end
        vectors++;
        if (m_rx.size() != 2 || m_rx[0] !== 8'hAA || m_rx[1] !== 8'h55) begin
            miscompares++;
            $display("FAIL burst_miso: got %0d bytes want aa,55", m_rx.size());
        end
        vectors++;
        if (urun_cnt != 0) begin
            miscompares++;
            $display("FAIL burst_underrun: got %0d want 0", urun_cnt);
        end
    endtask

    task automatic test_tx_ignore();
        set_mode(2'b01);
        clear_obs();
        preload(8'h4D);
        sif.i_TX_Byte = 8'hE2;
        sif.i_TX_DV   = 1'b1;
        @(negedge clk);
        sif.i_TX_DV   = 1'b0;
        m_tx = '{8'h01, 8'h02};
        master_xfer(16, 0, 8'h00);
        vectors++;
        if (m_rx.size() != 2 || m_rx[0] !== 8'h4D || m_rx[1] !== 8'h00) begin
            miscompares++;
            $display("FAIL ignore_miso: got %h,%h want 4d,00",
                     m_rx.size() > 0 ? m_rx[0] : 8'hxx,
                     m_rx.size() > 1 ? m_rx[1] : 8'hxx);
        end
        vectors++;
        if (urun_cnt != 1) begin
            miscompares++;
            $display("FAIL ignore_underrun: got %0d want 1", urun_cnt);
        end
    endtask

    task automatic test_bypass();
        set_mode(2'b00);
        clear_obs();
        m_tx = '{8'h33};
        master_xfer(8, 1, 8'hC7);
        check_miso1("bypass_miso", 8'hC7);
        check_rx1("bypass_rx", 8'h33);
        vectors++;
        if (urun_cnt != 1) begin
            miscompares++;
            $display("FAIL bypass_underrun: got %0d want 1", urun_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        set_mode(2'b00);
        @(negedge clk);
        sif.i_SPI_CS_n = 1'b0;
        sif.i_SPI_MOSI = 1'b1;
        repeat (H) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            sif.i_SPI_Clk = 1'b1;
            repeat (H) @(negedge clk);
            sif.i_SPI_Clk = 1'b0;
            repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_reset("reset_midframe");
        sif.i_SPI_CS_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_obs();
        m_tx = '{8'h96};
        master_xfer(8, 0, 8'h00);
        check_rx1("reset_next_rx", 8'h96);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [1:0] m;
            int nb, exp_ur;
            bit pre;
            logic [7:0] pv;
            m   = 2'($urandom_range(0, 3));
            nb  = $urandom_range(1, 3);
            pre = 1'($urandom_range(0, 1));
            pv  = 8'($urandom);
            set_mode(m);
            clear_obs();
            m_tx.delete();
            for (int k = 0; k < nb; k++) m_tx.push_back(8'($urandom));
            if (pre) preload(pv);
            master_xfer(8 * nb, 0, 8'h00);
            exp_ur = (m[0] ? nb : nb + 1) - (pre ? 1 : 0);
            vectors++;
            if (rx_q.size() != nb) begin
                miscompares++;
                $display("FAIL rand%0d_rxcnt: got %0d want %0d",
                         it, rx_q.size(), nb);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    vectors++;
                    if (rx_q[k] !== m_tx[k]) begin
                        miscompares++;
                        $display("FAIL rand%0d_rx%0d: got %h want %h",
                                 it, k, rx_q[k], m_tx[k]);
                    end
                end
            end
            for (int k = 0; k < m_rx.size(); k++) begin
                logic [7:0] w;
                w = (k == 0 && pre) ? pv : 8'h00;
                vectors++;
                if (m_rx[k] !== w) begin
                    miscompares++;
                    $display("FAIL rand%0d_miso%0d: got %h want %h",
                             it, k, m_rx[k], w);
                end
            end
            vectors++;
            if (urun_cnt != exp_ur || sif.o_TX_Ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rand%0d_ur: got %0d rdy %b want %0d rdy 1",
                         it, urun_cnt, sif.o_TX_Ready, exp_ur);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_all_modes();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_tx_ignore();
        test_bypass();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_all_modes.md
Name: spi_slave_all_modes

Overview:
SPI slave (target) for all four CPOL/CPHA modes; it is the far-end partner of the team's SPI master. It oversamples the SPI pins in the i_Clk domain, deserialises MOSI into bytes and serialises a user-supplied byte onto MISO, MSB first. A one-deep TX holding register lets firmware preload the next response byte. Multi-byte frames are supported while CS_n stays low.

Parameters:
SYNC_STAGES, 2, flip-flop stages on i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI; legal values are 2 or more.

Ports:
i_Clk  in  1  system clock; must run at 8x SCLK or faster.
i_Rst_L  in  1  reset, asynchronous, active-low.
i_CPOL  in  1  0 = SCLK idle low, 1 = SCLK idle high.
i_CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
i_TX_Byte  in  8  next MISO byte.
i_TX_DV  in  1  write strobe for i_TX_Byte; accepted only when o_TX_Ready = 1.
o_TX_Ready  out  1  TX holding register is empty.
o_TX_Underrun  out  1  1-cycle pulse: a byte load found the holding register empty, so 0x00 was sent.
o_RX_DV  out  1  1-cycle pulse: o_RX_Byte is valid.
o_RX_Byte  out  8  last complete received byte.
i_SPI_Clk  in  1  SCLK from the master (asynchronous).
i_SPI_MOSI  in  1  MOSI (asynchronous).
i_SPI_CS_n  in  1  chip select, active low (asynchronous).
o_SPI_MISO  out  1  MISO data.
o_SPI_MISO_OE  out  1  MISO output enable; 1 only while the frame is active.

Behaviour:
- Reset values: o_TX_Ready = 1, o_TX_Underrun = 0, o_RX_DV = 0, o_RX_Byte = 0x00, o_SPI_MISO = 0, o_SPI_MISO_OE = 0. The state machine goes to IDLE, the bit counter to 0, and the holding register is marked empty. The synchronisers reset to CS_n = 1 and SCLK = 0.
- Synchronisation: SCLK, CS_n and MOSI each pass through SYNC_STAGES flops. Edges are found by comparing the last synced value with one extra register. All internal events occur SYNC_STAGES+1 cycles after the pin change.
- Edge definitions:
  - Leading edge: SCLK leaves the CPOL level.
  - Trailing edge: SCLK returns to the CPOL level.
  - CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- Mode latching: i_CPOL and i_CPHA are latched on the CS_n falling detect. Changes to these inputs mid-frame are ignored.
- State machine (2 states):
  - IDLE -> ACTIVE on a CS_n falling detect. The bit counter is cleared and OE goes to 1.
  - ACTIVE -> IDLE on a CS_n rising detect. OE goes to 0 and o_SPI_MISO goes to 0.
  - SCLK edges seen in IDLE are ignored.
- Byte load (holding register -> shift register; o_TX_Ready rises the next cycle):
  - CPHA=0: load at CS_n fall and on every trailing edge that ends bit 0. o_SPI_MISO drives bit7 in the same cycle as the load.
  - CPHA=1: load on the leading edge of bit7. The same edge drives bit7.
  - If the holding register is empty at the load point, shift 0x00 and pulse o_TX_Underrun.
  - If i_TX_DV arrives in the load cycle while the holding register is empty, bypass i_TX_Byte straight into the shift register. No underrun is flagged and o_TX_Ready stays 1.
- Shift: on each shift edge after the load, o_SPI_MISO takes the next lower bit.
- Sample: on each sample edge, the synced MOSI enters the RX shifter LSB-side and the bit counter increments, wrapping 7 -> 0.
  - On the 8th sample, o_RX_Byte is updated and o_RX_DV pulses in the next cycle.
  - Further bytes in the same frame repeat the cycle with no gap.
- CS_n rising mid-byte: the partial byte is discarded and no o_RX_DV is produced. The holding register is kept. The shift-register contents are lost; there is no underrun pulse.
- i_TX_DV while o_TX_Ready = 0: ignored, and the holding register is unchanged.
- Reset asserted mid-frame: all state goes to reset values immediately (asynchronously), and OE drops.

Decomposition:
- Shared package spi_pkg holds:
  - the state encodings IDLE and ACTIVE;
  - mode constants for the 2-bit {CPOL,CPHA} values MODE0..MODE3;
  - SPI_BYTE_W = 8.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchroniser with rise/fall pulse outputs. Instance it for SCLK and for CS_n; MOSI uses only its synced output.

Test Plan:
- Mode 0: preload 0x3C, then the master (CLKS_PER_HALF_BIT = 4) sends 0xA5 -> exactly one o_RX_DV pulse with o_RX_Byte = 0xA5; the master receives 0x3C; o_TX_Ready returns to 1 after the load.
- All four modes: preload 0x81, master sends 0x7E -> slave receives 0x7E and master receives 0x81 in every mode; OE = 1 exactly between the CS_n fall and rise detects.
- Underrun: no preload, master sends 0xFF -> master receives 0x00; one o_TX_Underrun pulse; o_RX_Byte = 0xFF.
- Abort: CS_n is raised after 5 SCLK cycles of 0xC3 -> no o_RX_DV, OE drops; the next full transfer of 0x5A gives o_RX_Byte = 0x5A.
- Burst (directed bench, CS_n held low for 16 bits of 0x11, 0x22): preload 0xAA, write 0x55 after o_TX_Ready rises -> RX pulses 0x11 then 0x22; MISO stream = 0xAA then 0x55; no underrun.
- Reset: i_Rst_L is pulsed low at bit 3 of a transfer -> all outputs at reset values the same cycle; a following transfer of 0x96 is received correctly.
